// File: rtl/pattern_scan_loader.sv
// Scan-port programming master: shifts a frame of BUFFER_SIZE words MSB-first
// into the pattern buffer selected by saddr over sclk/sin/ssel, and returns
// the bits shifted out on sout as readback words.
module pattern_scan_loader #(
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned BUFFER_SIZE  = 22,
  parameter int unsigned CLK_DIV      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              start_addr,
  input  logic [BUFFER_WIDTH-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    sclk,
  output logic                    sin,
  output logic                    ssel,
  output logic [2:0]              saddr,
  input  logic                    sout,
  output logic [BUFFER_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BCW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam int unsigned WCW = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(BUFFER_WIDTH - 1);
  localparam logic [WCW-1:0] WORD_ALL = WCW'(BUFFER_SIZE);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [BUFFER_WIDTH-1:0] sh_q, sh_d;
  logic [BUFFER_WIDTH-2:0] rx_q, rx_d;
  logic [BUFFER_WIDTH-1:0] rx_full;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [DCW-1:0]          div_cnt_q, div_cnt_d;
  logic                    phase_q, phase_d;      // 0: sclk low half, 1: sclk high half
  logic [2:0]              saddr_q, saddr_d;
  logic [BUFFER_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  logic half_end;
  logic bit_end;
  logic word_end;
  logic frame_end;
  logic boundary_ready;

  assign half_end       = (div_cnt_q == DIV_LAST);
  assign bit_end        = (state_q == S_SHIFT) && phase_q && half_end;
  assign word_end       = bit_end && (bit_cnt_q == BIT_LAST);
  assign frame_end      = word_end && (word_cnt_q == WORD_ALL);
  assign boundary_ready = word_end && (word_cnt_q != WORD_ALL);
  assign rx_full        = {rx_q, sout};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (wr_valid) state_d = S_SHIFT;
      S_SHIFT: begin
        if (frame_end)                  state_d = S_HOLD;
        else if (word_end && !wr_valid) state_d = S_LOAD;
      end
      S_HOLD:  if (half_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and bit phase
  always_comb begin
    wr_ready = (state_q == S_LOAD) || boundary_ready;
    sclk     = (state_q == S_SHIFT) && phase_q;
    ssel     = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_HOLD);
    busy     = ssel;
    done     = (state_q == S_DONE);
    sin      = sh_q[BUFFER_WIDTH-1];
    saddr    = saddr_q;
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
  end

  // Datapath next-state: bit timing, word counting, shift and capture registers
  always_comb begin
    sh_d       = sh_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    div_cnt_d  = div_cnt_q;
    phase_d    = phase_q;
    saddr_d    = saddr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          saddr_d    = start_addr;
          word_cnt_d = '0;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          phase_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (wr_valid) begin
          sh_d       = wr_data;
          word_cnt_d = word_cnt_q + 1'b1;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          phase_d    = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!half_end) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of a bit: capture sout, then either advance within the word
            // or close the word. The last bit is not shifted out so that sin
            // keeps presenting it while stalled in LOAD or HOLD.
            phase_d = 1'b0;
            rx_d    = rx_full[BUFFER_WIDTH-2:0];
            if (bit_cnt_q != BIT_LAST) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              sh_d      = {sh_q[BUFFER_WIDTH-2:0], 1'b0};
            end else begin
              bit_cnt_d  = '0;
              rd_data_d  = rx_full;
              rd_valid_d = 1'b1;
              if (boundary_ready && wr_valid) begin
                sh_d       = wr_data;
                word_cnt_d = word_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      S_HOLD: begin
        if (half_end) div_cnt_d = '0;
        else          div_cnt_d = div_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      div_cnt_q  <= '0;
      phase_q    <= 1'b0;
      saddr_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      saddr_q    <= saddr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_pattern_scan_loader.sv
// Directed-plus-random bench for pattern_scan_loader with a bit-stream model of
// the downstream scan chain and frame-level expectations.
module tb_pattern_scan_loader;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 22;
  localparam int unsigned DIV = 2;
  localparam int unsigned DLY = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, wr_valid, wr_ready, sclk, sin, ssel, sout, rd_valid, busy, done;
  logic [2:0]   start_addr, saddr;
  logic [W-1:0] wr_data, rd_data;

  pattern_scan_loader #(.BUFFER_WIDTH(W), .BUFFER_SIZE(N), .CLK_DIV(DIV)) u_dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .sclk(sclk), .sin(sin), .ssel(ssel), .saddr(saddr), .sout(sout),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  logic         s_start, s_wr_valid, s_wr_ready, s_sclk, s_sin, s_ssel, s_sout, s_rd_valid, s_busy, s_done;
  logic [2:0]   s_start_addr, s_saddr;
  logic [W-1:0] s_wr_data, s_rd_data;

  pattern_scan_loader #(.BUFFER_WIDTH(W), .BUFFER_SIZE(2), .CLK_DIV(1)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .start_addr(s_start_addr),
    .wr_data(s_wr_data), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .sclk(s_sclk), .sin(s_sin), .ssel(s_ssel), .saddr(s_saddr), .sout(s_sout),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .busy(s_busy), .done(s_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan chain model: sout is the sin stream delayed by one full buffer.
  bit           chain_q[$];
  logic [W-1:0] cur_words [N];
  logic [W-1:0] prev_words [N];

  int           f_ssel_cycles, f_first_ssel, f_done_at, f_done_cnt, f_rises;
  int           f_accepted, f_rd_cnt, f_saddr_bad, f_busy_bad, f_sin_bad;
  bit           f_finished;
  bit           f_sin_bits[$];
  bit           f_sout_bits[$];
  logic [W-1:0] f_rd_words[$];

  task automatic run_frame(input logic [2:0] addr, input int stall_word, input int stall_len,
                           input int abort_rise, input bit poke_start);
    int   widx = 0;
    int   stall_left = 0;
    bit   stall_used = 0;
    bit   do_abort = 0;
    int   cyc = 1;
    int   post_bad = 0;
    logic prev_sclk, prev_sin;
    f_ssel_cycles = 0; f_first_ssel = -1; f_done_at = -1; f_done_cnt = 0; f_rises = 0;
    f_accepted = 0; f_rd_cnt = 0; f_saddr_bad = 0; f_busy_bad = 0; f_sin_bad = 0;
    f_finished = 0;
    f_sin_bits.delete(); f_sout_bits.delete(); f_rd_words.delete();
    start = 1'b1; start_addr = addr; wr_valid = 1'b0; wr_data = '0;
    @(posedge clk); #1;
    start = 1'b0; start_addr = ~addr;
    prev_sclk = 1'b0; prev_sin = sin;
    while (!f_finished && cyc < 5000) begin
      if (ssel) begin
        f_ssel_cycles++;
        if (f_first_ssel < 0) f_first_ssel = cyc;
        if (saddr !== addr) f_saddr_bad++;
      end
      if (busy !== ssel) f_busy_bad++;
      if (sclk && (sin !== prev_sin)) f_sin_bad++;
      if (sclk && !prev_sclk) begin
        f_rises++;
        f_sin_bits.push_back(sin);
        chain_q.push_back(sin);
        if (chain_q.size() > DLY) sout = chain_q.pop_front();
        else                      sout = 1'b0;
        f_sout_bits.push_back(sout);
        if (abort_rise > 0 && f_rises == abort_rise) do_abort = 1;
      end
      if (rd_valid) begin f_rd_cnt++; f_rd_words.push_back(rd_data); end
      if (done) begin f_done_cnt++; if (f_done_at < 0) f_done_at = cyc; end
      if (f_done_at >= 0 && cyc >= f_done_at + 3) f_finished = 1;
      prev_sclk = sclk; prev_sin = sin;
      if (do_abort) begin
        wr_valid = 1'b0; start = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ssel", ssel, 1'b0);
        check("abort_sclk", sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        for (int i = 0; i < 30; i++) begin
          if (done || ssel || sclk || wr_ready) post_bad++;
          @(posedge clk); #1;
        end
        check("abort_no_done", post_bad, 0);
        f_finished = 1;
      end else begin
        if (!stall_used && stall_len > 0 && widx == stall_word && wr_ready) begin
          stall_used = 1; stall_left = stall_len;
        end
        if (stall_left > 0) begin wr_valid = 1'b0; stall_left--; end
        else                      wr_valid = 1'b1;
        if (widx < int'(N)) wr_data = cur_words[widx];
        else                wr_data = W'($urandom);
        if (wr_valid && wr_ready) begin f_accepted++; widx++; end
        if (poke_start && (cyc % 97) == 50) begin start = 1'b1; start_addr = 3'($urandom); end
        else start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    wr_valid = 1'b0; start = 1'b0;
    check("frame_terminated", f_finished, 1'b1);
  endtask

  task automatic check_frame(input logic [2:0] addr, input int stall_len);
    logic [W-1:0] w;
    int exp_len = 1 + N * W * 2 * DIV + DIV + stall_len;
    check("ssel_first", f_first_ssel, 1);
    check("ssel_len", f_ssel_cycles, exp_len);
    check("done_at", f_done_at, 1 + exp_len);
    check("done_cnt", f_done_cnt, 1);
    check("sclk_rises", f_rises, N * W);
    check("accepted", f_accepted, N);
    check("saddr_stable", f_saddr_bad, 0);
    check("saddr_hold", saddr, addr);
    check("busy_eq_ssel", f_busy_bad, 0);
    check("sin_stable_high", f_sin_bad, 0);
    check("rd_cnt", f_rd_cnt, N);
    if (f_sin_bits.size() == N * W && f_rd_words.size() == N) begin
      for (int j = 0; j < int'(N); j++) begin
        w = '0;
        for (int b = 0; b < int'(W); b++) w = {w[W-2:0], f_sin_bits[j*W+b]};
        check($sformatf("sin_word%0d", j), w, cur_words[j]);
        w = '0;
        for (int b = 0; b < int'(W); b++) w = {w[W-2:0], f_sout_bits[j*W+b]};
        check($sformatf("rd_word%0d", j), f_rd_words[j], w);
      end
    end
  endtask

  initial begin
    int           bad, cyc, rises, last_rise, bad_iv, done_at, acc, sidx, rdc;
    bit           fin;
    logic [2:0]   addr;
    logic [W-1:0] s_words [2];
    logic [W-1:0] s_rd [2];
    bit           s_bits[$];
    logic [W-1:0] w;

    reset = 1'b1; start = 1'b0; start_addr = '0; wr_data = '0; wr_valid = 1'b0; sout = 1'b0;
    s_start = 1'b0; s_start_addr = '0; s_wr_data = '0; s_wr_valid = 1'b0; s_sout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {wr_ready, sclk, sin, ssel, saddr, rd_data, rd_valid, busy, done}, '0);
    reset = 1'b0;

    // 1: idle after reset
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({wr_ready, sclk, sin, ssel, saddr, rd_data, rd_valid, busy, done} !== '0) bad++;
    end
    check("idle_outputs", bad, 0);

    // 2: counting words to address 5; chain starts empty
    chain_q.delete();
    for (int j = 0; j < int'(N); j++) cur_words[j] = W'(j);
    run_frame(3'd5, -1, 0, 0, 1'b0);
    check_frame(3'd5, 0);
    for (int j = 0; j < int'(N); j++) prev_words[j] = cur_words[j];

    // 3: random frame, readback must return the first frame; stray starts
    for (int j = 0; j < int'(N); j++) cur_words[j] = W'($urandom);
    addr = 3'($urandom);
    run_frame(addr, -1, 0, 0, 1'b1);
    check_frame(addr, 0);
    if (f_rd_words.size() == N)
      for (int j = 0; j < int'(N); j++)
        check($sformatf("loopback%0d", j), f_rd_words[j], prev_words[j]);

    // 4: wr_valid dropped for 10 cycles after word 3
    for (int j = 0; j < int'(N); j++) cur_words[j] = W'($urandom);
    addr = 3'($urandom);
    run_frame(addr, 4, 10, 0, 1'b0);
    check_frame(addr, 10);

    // 5: stray starts then reset at bit 40, followed by a clean frame
    for (int j = 0; j < int'(N); j++) cur_words[j] = W'($urandom);
    run_frame(3'd6, -1, 0, 41, 1'b1);
    check("abort_rises", f_rises, 41);
    check("abort_done_cnt", f_done_cnt, 0);
    for (int j = 0; j < int'(N); j++) cur_words[j] = W'($urandom);
    addr = 3'($urandom);
    run_frame(addr, -1, 0, 0, 1'b0);
    check_frame(addr, 0);

    // 6: CLK_DIV=1, BUFFER_SIZE=2 instance
    s_words[0] = W'($urandom); s_words[1] = W'($urandom);
    s_start = 1'b1; s_start_addr = 3'd2;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 1; bad = 0; rises = 0; last_rise = 0; bad_iv = 0; done_at = -1; acc = 0; sidx = 0;
    rdc = 0; fin = 0; s_rd[0] = 'x; s_rd[1] = 'x;
    while (!fin && cyc < 200) begin
      if (s_ssel) bad++;
      if (s_sclk && !(rises > 0 && last_rise == cyc - 1)) begin
        if (rises > 0 && cyc - last_rise != 2) bad_iv++;
        rises++; last_rise = cyc; s_bits.push_back(s_sin);
      end
      if (s_rd_valid) begin if (rdc < 2) s_rd[rdc] = s_rd_data; rdc++; end
      if (s_done && done_at < 0) done_at = cyc;
      if (done_at >= 0 && cyc >= done_at + 2) fin = 1;
      s_wr_valid = 1'b1;
      if (sidx < 2) s_wr_data = s_words[sidx];
      else          s_wr_data = W'($urandom);
      if (s_wr_valid && s_wr_ready) begin acc++; sidx++; end
      @(posedge clk); #1;
      cyc++;
    end
    s_wr_valid = 1'b0;
    check("small_terminated", fin, 1'b1);
    check("small_ssel_len", bad, 34);
    check("small_rises", rises, 16);
    check("small_sclk_period", bad_iv, 0);
    check("small_done_at", done_at, 35);
    check("small_accepted", acc, 2);
    check("small_saddr", s_saddr, 3'd2);
    check("small_rd_cnt", rdc, 2);
    check("small_rd0", s_rd[0], '0);
    check("small_rd1", s_rd[1], '0);
    if (s_bits.size() == 16)
      for (int j = 0; j < 2; j++) begin
        w = '0;
        for (int b = 0; b < int'(W); b++) w = {w[W-2:0], s_bits[j*W+b]};
        check($sformatf("small_sin_word%0d", j), w, s_words[j]);
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
